mul_share_arb: RTL and testbench

//  Shares one pipelined mul_signed_64 among NREQ requesters. Round-robin grant, at most one issue per cycle.

---
 rtl/mul_share_arb.sv | 169 ++++++++++++++++
 tb/tb_mul_share_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one pipelined signed 64x64 multiplier among NREQ requesters, results via credit-gated FIFO.
// Build option MUL_ARB_PRIO_EN: requester 0 gets strict priority, round-robin among the rest.
`timescale 1ns/1ps
module mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 3,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  output logic                 mul_stb,
  output logic [63:0]          mul_din1,
  output logic [63:0]          mul_din2,
  input  logic                 mul_valid_out,
  input  logic [127:0]         mul_dout,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [IDW-1:0]       rsp_id,
  output logic [127:0]         rsp_dout,
  output logic                 err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef MUL_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_used;
  logic             r_mul_stb;
  logic [63:0]      r_din1, r_din2;
  logic             r_tag_vld [0:MUL_LAT];
  logic [IDW-1:0]   r_tag_id  [0:MUL_LAT];
  logic [IDW+127:0] r_mem     [0:DEPTH-1];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [IDW-1:0]   r_head_id;
  logic [127:0]     r_head_dout;
  logic             r_err;

  logic             w_gnt_any;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW:0]     w_cand;
  logic [63:0]      w_opa [0:NREQ-1];
  logic [63:0]      w_opb [0:NREQ-1];
  logic             w_tag_v, w_push, w_pop, w_lost;
  logic [IDW-1:0]   w_tag_id;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_op
      assign w_opa[gi] = req_a[gi*64 +: 64];
      assign w_opb[gi] = req_b[gi*64 +: 64];
    end
  endgenerate

  // Search starts one past the last winner; credits gate the whole grant.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (rst_n && (r_used < CW'(DEPTH))) begin
      if (PRIO && req_vld[0]) begin
        w_gnt_any = 1'b1;
      end
      for (int k = 1; k <= NREQ; k++) begin
        w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_cand >= (IDW+1)'(NREQ)) begin
          w_cand = w_cand - (IDW+1)'(NREQ);
        end
        if (!w_gnt_any && req_vld[w_cand[IDW-1:0]] && !(PRIO && (w_cand == '0))) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (w_gnt_any) begin
      req_rdy[w_gnt_idx] = 1'b1;
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign w_tag_v  = r_tag_vld[MUL_LAT];
  assign w_tag_id = r_tag_id[MUL_LAT];
  assign w_push   = mul_valid_out & w_tag_v;
  assign w_lost   = w_tag_v & ~mul_valid_out;
  assign w_pop    = (r_count != '0) & rsp_rdy;

  // Stage 0 loads on the same edge as mul_stb, so stage MUL_LAT lines up with mul_valid_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= IDW'(NREQ-1);
      r_mul_stb <= 1'b0;
      r_din1    <= '0;
      r_din2    <= '0;
      for (int s = 0; s <= MUL_LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_id[s]  <= '0;
      end
    end else begin
      r_mul_stb    <= w_gnt_any;
      r_tag_vld[0] <= w_gnt_any;
      r_tag_id[0]  <= w_gnt_idx;
      for (int s = 1; s <= MUL_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      if (w_gnt_any) begin
        r_din1 <= w_opa[w_gnt_idx];
        r_din2 <= w_opb[w_gnt_idx];
        if (!(PRIO && (w_gnt_idx == '0))) begin
          r_ptr <= w_gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_tag_id, mul_dout};
    end
  end

  // Head register: refilled from the array on pop, or bypassed when a push lands in an emptying FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_used      <= '0;
      r_head_id   <= '0;
      r_head_dout <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_used  <= r_used + CW'(w_gnt_any) - CW'(w_pop) - CW'(w_lost);
      r_err   <= r_err | (w_tag_v ^ mul_valid_out);
      if (w_push && ((r_count - CW'(w_pop)) == '0)) begin
        r_head_id   <= w_tag_id;
        r_head_dout <= mul_dout;
      end else if (w_pop && (r_count > CW'(1))) begin
        {r_head_id, r_head_dout} <= r_mem[ptr_inc(r_rd_ptr)];
      end
    end
  end

  assign mul_stb  = r_mul_stb;
  assign mul_din1 = r_din1;
  assign mul_din2 = r_din2;
  assign rsp_vld  = (r_count != '0);
  assign rsp_id   = r_head_id;
  assign rsp_dout = r_head_dout;
  assign err      = r_err;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: randomized bench with a pipelined multiplier model and a queue-based issue/response scoreboard.
`timescale 1ns/1ps
module tb_mul_share_arb;
  localparam int NREQ = 4, IDW = 2, MUL_LAT = 3, DEPTH = 8;
`ifdef MUL_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                clk, rst_n;
  logic [NREQ-1:0]     req_vld, req_rdy;
  logic [NREQ*64-1:0]  req_a, req_b;
  logic                mul_stb, mul_valid_out;
  logic [63:0]         mul_din1, mul_din2;
  logic [127:0]        mul_dout, rsp_dout;
  logic                rsp_vld, rsp_rdy, err;
  logic [IDW-1:0]      rsp_id;
  logic                inj;

  mul_share_arb #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .mul_stb(mul_stb), .mul_din1(mul_din1), .mul_din2(mul_din2), .mul_valid_out(mul_valid_out),
    .mul_dout(mul_dout), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ea, eb;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    return ea * eb;
  endfunction

  // Multiplier model: fixed MUL_LAT pipe, cleared by the shared reset.
  logic         mv_pipe [0:MUL_LAT-1];
  logic [127:0] mp_pipe [0:MUL_LAT-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) mv_pipe[i] <= 1'b0;
    end else begin
      mv_pipe[0] <= mul_stb;
      mp_pipe[0] <= smul(mul_din1, mul_din2);
      for (int i = 1; i < MUL_LAT; i++) begin
        mv_pipe[i] <= mv_pipe[i-1];
        mp_pipe[i] <= mp_pipe[i-1];
      end
    end
  end
  assign mul_valid_out = mv_pipe[MUL_LAT-1] | inj;
  assign mul_dout      = mp_pipe[MUL_LAT-1];

  typedef struct {
    int           id;
    logic [127:0] p;
    longint       rdy;
  } exp_t;
  exp_t   sb[$];
  int     m_ptr;
  bit     m_err;
  longint cyc;
  int     checks, errors, n_xfer;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whoever is next after the last winner gets the grant when fewer than DEPTH ops are outstanding.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ptr = NREQ - 1;
      m_err = 1'b0;
    end else begin
      int g;
      logic [NREQ-1:0] eg;
      bit exp_vld;
      exp_t e;
      g = -1;
      if (sb.size() < DEPTH) begin
        if (PRIO && req_vld[0]) g = 0;
        for (int k = 1; k <= NREQ && g < 0; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (!(PRIO && c == 0) && req_vld[c]) g = c;
        end
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      checks++;
      if (req_rdy !== eg) begin
        errors++;
        $display("FAIL grant cyc=%0d req_rdy=%b expected %b", cyc, req_rdy, eg);
      end
      exp_vld = (sb.size() > 0) && (sb[0].rdy <= cyc);
      checks++;
      if (rsp_vld !== exp_vld) begin
        errors++;
        $display("FAIL rsp_vld cyc=%0d got %b expected %b", cyc, rsp_vld, exp_vld);
      end
      if (rsp_vld && exp_vld) begin
        checks++;
        if (rsp_id !== IDW'(sb[0].id) || rsp_dout !== sb[0].p) begin
          errors++;
          $display("FAIL rsp_data cyc=%0d id=%0d dout=%h expected id=%0d dout=%h",
                   cyc, rsp_id, rsp_dout, sb[0].id, sb[0].p);
        end
      end
      if (rsp_vld && rsp_rdy && sb.size() > 0) void'(sb.pop_front());
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL err cyc=%0d got %b expected %b", cyc, err, m_err);
      end
      if (g >= 0) begin
        e.id  = g;
        e.p   = smul(req_a[g*64 +: 64], req_b[g*64 +: 64]);
        e.rdy = cyc + MUL_LAT + 2;
        sb.push_back(e);
        if (!(PRIO && g == 0)) m_ptr = g;
        n_xfer++;
      end
    end
  end

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*64 +: 64] = rand_opnd();
      req_b[i*64 +: 64] = rand_opnd();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0; req_vld = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst_n = 1'b0; req_vld = '1;
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== '0 || mul_stb !== 1'b0) begin
      errors++; $display("FAIL reset_issue req_rdy=%b mul_stb=%b expected 0", req_rdy, mul_stb);
    end
    checks++;
    if (mul_din1 !== '0 || mul_din2 !== '0) begin
      errors++; $display("FAIL reset_din din1=%h din2=%h expected 0", mul_din1, mul_din2);
    end
    checks++;
    if (rsp_vld !== 1'b0 || rsp_id !== '0 || rsp_dout !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp vld=%b id=%0d dout=%h err=%b expected all 0", rsp_vld, rsp_id, rsp_dout, err);
    end
    rst_n = 1'b1; req_vld = '0;
  endtask

  task automatic test_single();
    int n;
    logic [127:0] m21;
    m21 = -128'sd21;
    rsp_rdy = 1'b1;
    @(posedge clk); #1 rand_ops();
    req_a[63:0] = -64'sd3; req_b[63:0] = 64'sd7; req_vld = 4'b0001;
    #1 checks++;
    if (req_rdy !== 4'b0001) begin
      errors++; $display("FAIL single_grant req_rdy=%b expected 0001", req_rdy);
    end
    @(posedge clk); #1 req_vld = '0;
    checks++;
    if (mul_stb !== 1'b1 || mul_din1 !== 64'hFFFF_FFFF_FFFF_FFFD || mul_din2 !== 64'd7) begin
      errors++; $display("FAIL single_issue stb=%b din1=%h din2=%h expected 1 -3 7", mul_stb, mul_din1, mul_din2);
    end
    n = 0;
    while (!rsp_vld && n < 20) begin @(posedge clk); #1 n++; end
    checks++;
    if (n != MUL_LAT + 1) begin
      errors++; $display("FAIL single_latency got %0d cycles after issue expected %0d", n, MUL_LAT + 1);
    end
    checks++;
    if (rsp_vld !== 1'b1 || rsp_id !== '0 || rsp_dout !== m21) begin
      errors++; $display("FAIL single_rsp vld=%b id=%0d dout=%h expected 1 0 %h", rsp_vld, rsp_id, rsp_dout, m21);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int ids[$];
    apply_reset();
    rsp_rdy = 1'b1; rand_ops(); req_vld = '1;
    for (int i = 0; i < 12 + 10; i++) begin
      logic [NREQ-1:0] eg;
      #1;
      if (rsp_vld) ids.push_back(int'(rsp_id));
      if (i < 12) begin
        eg = '0;
        eg[PRIO ? 0 : (i % NREQ)] = 1'b1;
        checks++;
        if (req_rdy !== eg) begin
          errors++; $display("FAIL rr_grant step=%0d req_rdy=%b expected %b", i, req_rdy, eg);
        end
      end
      @(posedge clk); #1 rand_ops();
      if (i == 11) req_vld = '0;
    end
    checks++;
    if (ids.size() != 12) begin
      errors++; $display("FAIL rr_count responses=%0d expected 12", ids.size());
    end
    for (int i = 0; i < ids.size() && i < 12; i++) begin
      checks++;
      if (ids[i] != (PRIO ? 0 : i % NREQ)) begin
        errors++; $display("FAIL rr_order idx=%0d id=%0d expected %0d", i, ids[i], PRIO ? 0 : i % NREQ);
      end
    end
  endtask

  task automatic test_backpressure();
    int nx, np;
    apply_reset();
    rsp_rdy = 1'b0; rand_ops(); req_vld = '1; nx = 0; np = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (|(req_vld & req_rdy)) nx++;
      @(posedge clk); #1 rand_ops();
    end
    #1 checks++;
    if (nx != DEPTH || req_rdy !== '0) begin
      errors++; $display("FAIL bp_fill transfers=%0d req_rdy=%b expected %0d and 0", nx, req_rdy, DEPTH);
    end
    req_vld = '0; rsp_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 if (rsp_vld) np++;
      @(posedge clk); #1;
    end
    checks++;
    if (np != DEPTH) begin
      errors++; $display("FAIL bp_drain pops=%0d expected %0d", np, DEPTH);
    end
    req_vld = '1;
    #1 checks++;
    if (req_rdy === '0) begin
      errors++; $display("FAIL bp_resume req_rdy=%b expected a grant", req_rdy);
    end
    @(posedge clk); #1 req_vld = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int target, mode;
    target = n_xfer + 1000;
    for (int i = 0; i < 20000 && n_xfer < target; i++) begin
      @(posedge clk); #1 rand_ops();
      for (int r = 0; r < NREQ; r++) req_vld[r] = ($urandom_range(0, 9) < 6);
      mode = (i / 40) % 3;
      if (mode == 0)      rsp_rdy = ~rsp_rdy;
      else if (mode == 1) rsp_rdy = ($urandom_range(0, 9) < 2);
      else                rsp_rdy = ($urandom_range(0, 9) < 9);
    end
    @(posedge clk); #1 req_vld = '0; rsp_rdy = 1'b1;
    checks++;
    if (n_xfer < target) begin
      errors++; $display("FAIL rand_progress transfers=%0d expected at least %0d", n_xfer, target);
    end
    repeat (20) @(posedge clk);
    #1 checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rand_drain outstanding=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, stale;
    logic [63:0] a, b;
    rsp_rdy = 1'b0; rand_ops(); req_vld = '1;
    repeat (5) begin @(posedge clk); #1 rand_ops(); end
    req_vld = '0;
    @(posedge clk); #1;
    checks++;
    if (rsp_vld !== 1'b1) begin
      errors++; $display("FAIL mid_queued rsp_vld=%b expected 1", rsp_vld);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== '0 || mul_stb !== 1'b0 || mul_din1 !== '0 || mul_din2 !== '0 ||
        rsp_vld !== 1'b0 || rsp_id !== '0 || rsp_dout !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL mid_reset stb=%b rsp_vld=%b id=%0d dout=%h err=%b expected all 0",
                         mul_stb, rsp_vld, rsp_id, rsp_dout, err);
    end
    rst_n = 1'b1; rsp_rdy = 1'b1; stale = 0;
    repeat (8) begin @(posedge clk); #1 if (rsp_vld) stale++; end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL mid_stale rsp_vld cycles=%0d expected 0", stale);
    end
    a = rand_opnd(); b = rand_opnd();
    req_a[63:0] = a; req_b[63:0] = b; req_vld = 4'b0001;
    @(posedge clk); #1 req_vld = '0;
    n = 0;
    while (!rsp_vld && n < 20) begin @(posedge clk); #1 n++; end
    checks++;
    if (rsp_vld !== 1'b1 || rsp_id !== '0 || rsp_dout !== smul(a, b)) begin
      errors++; $display("FAIL mid_next vld=%b id=%0d dout=%h expected 1 0 %h", rsp_vld, rsp_id, rsp_dout, smul(a, b));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    int pushes;
    repeat (8) @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0; m_err = 1'b1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL spur_err err=%b expected 1", err);
    end
    pushes = 0;
    repeat (6) begin @(posedge clk); #1 if (rsp_vld) pushes++; end
    checks++;
    if (err !== 1'b1 || pushes != 0) begin
      errors++; $display("FAIL spur_sticky err=%b rsp_vld cycles=%0d expected 1 and 0", err, pushes);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_a = '0; req_b = '0; rsp_rdy = 1'b1; inj = 1'b0;
    checks = 0; errors = 0; n_xfer = 0; m_ptr = NREQ - 1; m_err = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
